// File: rtl/tvout_pkg.sv
// tvout_pkg: shared framebuffer geometry, bus widths and fetch-state type for the TV output path
package tvout_pkg;
   localparam int WORDS_PER_LINE = 32;
   localparam int ACTIVE_LINES = 288;
   localparam int FB_WORDS = 9216;
   localparam int ADDR_W = 14;
   localparam int WORD_W = 16;
   typedef enum logic [1:0] {IDLE, REQ, DONE} fetch_state_t;
endpackage

// File: rtl/tv_word_fifo.sv
// tv_word_fifo: 2-entry x 16-bit word FIFO, head always in m0
// Ports: clk, reset (async, active-high), clr (sync flush), push/din (write),
//        pop (consume head), head (oldest word), count (0..2)
module tv_word_fifo
   import tvout_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] head,
   output logic [1:0]        count
);
   logic [WORD_W-1:0] m0, m1;
   logic              do_pop, do_push;
   logic [1:0]        cp;
   // cp is the occupancy after the pop, so a simultaneous push lands behind the surviving word
   always_comb begin
      do_pop  = pop && count != 2'd0;
      cp      = count - {1'b0, do_pop};
      do_push = push && cp != 2'd2;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         m0    <= '0;
         m1    <= '0;
         count <= 2'd0;
      end else if (clr) begin
         count <= 2'd0;
      end else begin
         m0    <= (do_push && cp == 2'd0) ? din : do_pop ? m1 : m0;
         m1    <= (do_push && cp == 2'd1) ? din : m1;
         count <= cp + {1'b0, do_push};
      end
   assign head = m0;
endmodule

// File: rtl/tv_pixel_fetch.sv
// tv_pixel_fetch: framebuffer word fetcher + 2-word FIFO + MSB-first pixel serializer
// Ports: clk, reset (async, active-high); pix_en/active/frame_start from video timing;
//        mem_req/mem_addr/mem_ack/mem_data to the framebuffer RAM; pix_out to video stage;
//        underrun = saturating underrun count, only built when TVOUT_UNDERRUN_EN is defined
module tv_pixel_fetch
   import tvout_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  logic              active,
   input  logic              frame_start,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_data,
   output logic              pix_out,
   output logic [7:0]        underrun
);
   localparam logic [ADDR_W-1:0] FB_END = ADDR_W'(FB_WORDS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
   fetch_state_t      state, state_nx;
   logic [1:0]        fifo_count;
   logic [WORD_W-1:0] head, sh;
   logic [3:0]        bit_cnt;
   logic              fifo_empty, load, push, pop;
   assign fifo_empty = fifo_count == 2'd0;
   // frame_start wins over both a same-clk ack and a same-clk pixel strobe
   assign load = pix_en && active && bit_cnt == 4'd0 && !frame_start;
   assign pop  = load && !fifo_empty;
   assign push = state == REQ && mem_ack && !frame_start;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   // mem_addr doubles as the words-fetched count since fetches are strictly linear from 0
   always_comb begin
      state_nx = state;
      if (frame_start) state_nx = IDLE;
      else if (state == IDLE && fifo_count < 2'd2 && mem_addr < FB_END) state_nx = REQ;
      else if (state == REQ && mem_ack) state_nx = (mem_addr == LAST_ADDR) ? DONE : IDLE;
   end
   always_comb mem_req = state == REQ;
   always_ff @(posedge clk or posedge reset)
      if (reset) mem_addr <= '0;
      else if (frame_start) mem_addr <= '0;
      else if (push) mem_addr <= mem_addr + 1'b1;
   tv_word_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (frame_start),
      .push  (push),
      .pop   (pop),
      .din   (mem_data),
      .head  (head),
      .count (fifo_count)
   );
   // An underrun load fills the shifter with zeros, so the whole word comes out blank
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sh      <= '0;
         bit_cnt <= 4'd0;
         pix_out <= 1'b0;
      end else if (frame_start) begin
         sh      <= '0;
         bit_cnt <= 4'd0;
      end else if (pix_en) begin
         if (!active) begin
            pix_out <= 1'b0;
         end else if (bit_cnt == 4'd0) begin
            sh      <= fifo_empty ? '0 : head;
            pix_out <= !fifo_empty && head[WORD_W-1];
            bit_cnt <= bit_cnt + 4'd1;
         end else begin
            sh      <= sh << 1;
            pix_out <= sh[WORD_W-2];
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
`ifdef TVOUT_UNDERRUN_EN
   logic [7:0] urun;
   always_ff @(posedge clk or posedge reset)
      if (reset) urun <= 8'd0;
      else if (load && fifo_empty && urun != 8'hff) urun <= urun + 8'd1;
   assign underrun = urun;
`else
   assign underrun = 8'd0;
`endif
endmodule
